// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed data RAM with a programmable read latency,
// serving the load/store port of the rriscv single-cycle core.
// Optional feature macro: DMEM_PERF_EN adds saturating read/write counters.
module data_mem_responder #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            rd_en_i,
  input  logic            wr_en_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] rdata_o,
  output logic            rdata_valid_o,
`ifdef DMEM_PERF_EN
  output logic [31:0]     rd_count_o,
  output logic [31:0]     wr_count_o,
`endif
  output logic            err_o
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = 4;

  // Reject latencies the 4-bit wait counter cannot express.
  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("data_mem_responder: LATENCY must be in 1..15");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   lat_addr_q, lat_addr_d;
  logic              lat_fault_q, lat_fault_d;
  logic [XLEN-1:0]   rdata_d;
  logic              valid_d;
  logic              err_d;

  logic [XLEN-1:0]   mem [DEPTH];

  logic              addr_bad_c;
  logic [IDX_W-1:0]  wr_idx_c;
  logic [IDX_W-1:0]  rd_idx_c;
  logic              wr_try_c;
  logic              wr_do_c;

  // Address legality: word aligned and word index inside the array.
  always_comb begin
    addr_bad_c = (addr_i[1:0] != 2'b00) ||
                 ({2'b00, addr_i[XLEN-1:2]} >= XLEN'(DEPTH));
    wr_idx_c   = addr_i[IDX_W+1:2];
  end

  // A store attempt is any wr_en_i except the rd+wr collision in IDLE, which
  // is a fault of its own. Outside IDLE the load port is already committed,
  // so a store alongside a held load (same address) is honoured.
  always_comb begin
    wr_try_c = wr_en_i && !(state_q == ST_IDLE && rd_en_i);
    wr_do_c  = wr_try_c && !addr_bad_c && !rst_i;
  end

  // Next-state, latch and registered-output computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lat_addr_d  = lat_addr_q;
    lat_fault_d = lat_fault_q;
    rdata_d     = rdata_o;
    valid_d     = 1'b0;
    err_d       = wr_try_c && addr_bad_c;
    rd_idx_c    = '0;

    case (state_q)
      ST_IDLE: begin
        if (rd_en_i && wr_en_i) begin
          err_d = 1'b1;
        end else if (rd_en_i) begin
          lat_addr_d  = addr_i;
          lat_fault_d = addr_bad_c;
          cnt_d       = CNT_W'(LATENCY - 1);
          state_d     = (LATENCY == 1) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!rd_en_i || (addr_i != lat_addr_q)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Response data is captured on entry to RESP; a store landing on the
    // same edge to the pending word is forwarded so it is not lost.
    if (state_d == ST_RESP) begin
      valid_d  = 1'b1;
      rd_idx_c = lat_addr_d[IDX_W+1:2];
      if (lat_fault_d) begin
        rdata_d = '0;
        err_d   = 1'b1;
      end else if (wr_do_c && (wr_idx_c == rd_idx_c)) begin
        rdata_d = wdata_i;
      end else begin
        rdata_d = mem[rd_idx_c];
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      lat_addr_q    <= '0;
      lat_fault_q   <= 1'b0;
      rdata_o       <= '0;
      rdata_valid_o <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      lat_addr_q    <= lat_addr_d;
      lat_fault_q   <= lat_fault_d;
      rdata_o       <= rdata_d;
      rdata_valid_o <= valid_d;
      err_o         <= err_d;
    end
  end

  // RAM array; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (wr_do_c) begin
      mem[wr_idx_c] <= wdata_i;
    end
  end

`ifdef DMEM_PERF_EN
  // Saturating counters of delivered responses and performed stores.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_count_o <= '0;
      wr_count_o <= '0;
    end else begin
      if (state_q == ST_RESP && rd_count_o != 32'hFFFF_FFFF) begin
        rd_count_o <= rd_count_o + 32'd1;
      end
      if (wr_do_c && wr_count_o != 32'hFFFF_FFFF) begin
        wr_count_o <= wr_count_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder (LATENCY=2, DEPTH=1024).
// Build with DMEM_PERF_EN defined to also exercise the counters.
module tb_data_mem_responder;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        err;
`ifdef DMEM_PERF_EN
  logic [31:0] rd_count;
  logic [31:0] wr_count;
`endif

  data_mem_responder #(.XLEN(XLEN), .DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .rd_en_i       (rd_en),
    .wr_en_i       (wr_en),
    .addr_i        (addr),
    .wdata_i       (wdata),
    .rdata_o       (rdata),
    .rdata_valid_o (rdata_valid),
`ifdef DMEM_PERF_EN
    .rd_count_o    (rd_count),
    .wr_count_o    (wr_count),
`endif
    .err_o         (err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference memory: what each legal word should hold.
  logic [31:0] ref_mem [DEPTH];

  function automatic logic addr_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && ((a >> 2) < DEPTH);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a store this cycle; returns err_o observed in the following cycle.
  task automatic store(input logic [31:0] a, input logic [31:0] d, output logic e);
    wr_en = 1'b1; addr = a; wdata = d;
    tick();
    wr_en = 1'b0; addr = '0; wdata = '0;
    e = err;
    if (addr_ok(a)) ref_mem[a >> 2] = d;
  endtask

  // Hold a load until the strobe (bounded), then idle two cycles counting strobes.
  task automatic load(input logic [31:0] a, output int lat, output logic [31:0] d,
                      output logic e, output int strobes);
    rd_en = 1'b1; addr = a; lat = -1; d = '0; e = 1'b0; strobes = 0;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      tick();
      if (rdata_valid) begin
        lat = k; d = rdata; e = err; strobes++;
      end
    end
    rd_en = 1'b0; addr = '0;
    for (int k = 0; k < 2; k++) begin
      tick();
      if (rdata_valid) strobes++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick(); tick();
    checks++; if (rdata_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", rdata_valid); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%0b exp=0", err); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_preload();
    logic e;
    for (int i = 0; i < 16; i++) begin
      store(32'(i * 4), $urandom, e);
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL preload_err word=%0d got=%0b exp=0", i, e); end
    end
    tick();
  endtask

  // Store at cycle 0, load from cycle 2, strobe only in cycle 4.
  task automatic test_basic();
    int c;
    c = 0;
    wr_en = 1'b1; addr = 32'h10; wdata = 32'hDEAD_BEEF;
    ref_mem[4] = 32'hDEAD_BEEF;
    tick(); c = 1;
    wr_en = 1'b0; addr = '0; wdata = '0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL basic_store_err got=%0b exp=0", err); end
    tick(); c = 2;
    rd_en = 1'b1; addr = 32'h10;
    for (int k = 0; k < 4; k++) begin
      tick(); c++;
      checks++;
      if (rdata_valid !== (c == 4)) begin
        errors++; $display("FAIL basic_valid cycle=%0d got=%0b exp=%0b", c, rdata_valid, (c == 4));
      end
      if (c == 4) begin
        checks++; if (rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL basic_data got=%h exp=deadbeef", rdata); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL basic_err got=%0b exp=0", err); end
        rd_en = 1'b0; addr = '0;
      end
    end
  endtask

  // Two loads with rd_en held; strobes LAT+1 cycles apart.
  task automatic test_back_to_back();
    int pos [2];
    logic [31:0] dat [2];
    int n;
    n = 0; pos[0] = -1; pos[1] = -1; dat[0] = '0; dat[1] = '0;
    rd_en = 1'b1; addr = 32'h10;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (rdata_valid) begin
        if (n < 2) begin pos[n] = k; dat[n] = rdata; end
        n++;
        if (n == 1) addr = 32'h14;
        else begin rd_en = 1'b0; addr = '0; end
      end
    end
    checks++; if (n !== 2) begin errors++; $display("FAIL b2b_strobes got=%0d exp=2", n); end
    checks++; if (pos[0] !== LAT) begin errors++; $display("FAIL b2b_first_pos got=%0d exp=%0d", pos[0], LAT); end
    checks++; if (pos[1] - pos[0] !== LAT + 1) begin errors++; $display("FAIL b2b_spacing got=%0d exp=%0d", pos[1] - pos[0], LAT + 1); end
    checks++; if (dat[0] !== ref_mem[4]) begin errors++; $display("FAIL b2b_data0 got=%h exp=%h", dat[0], ref_mem[4]); end
    checks++; if (dat[1] !== ref_mem[5]) begin errors++; $display("FAIL b2b_data1 got=%h exp=%h", dat[1], ref_mem[5]); end
  endtask

  task automatic test_misaligned_store();
    logic e; int lat; logic [31:0] d; int s;
    store(32'h11, 32'h1234_5678, e);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL misal_err got=%0b exp=1", e); end
    tick();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL misal_err_width got=%0b exp=0", err); end
    load(32'h10, lat, d, e, s);
    checks++; if (d !== ref_mem[4]) begin errors++; $display("FAIL misal_data got=%h exp=%h", d, ref_mem[4]); end
    checks++; if (e !== 1'b0 || s !== 1 || lat !== LAT) begin
      errors++; $display("FAIL misal_load got=err%0b/s%0d/lat%0d exp=err0/s1/lat%0d", e, s, lat, LAT);
    end
  endtask

  task automatic test_out_of_range();
    logic e; int lat; logic [31:0] d; int s;
    load(32'(4 * DEPTH), lat, d, e, s);
    checks++; if (lat !== LAT || s !== 1) begin errors++; $display("FAIL oor_timing got=lat%0d/s%0d exp=lat%0d/s1", lat, s, LAT); end
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL oor_data got=%h exp=0", d); end
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL oor_err got=%0b exp=1", e); end
  endtask

  task automatic test_abort_reset();
    logic e; int lat; logic [31:0] d; int s; int cnt;
    // rd_en dropped in WAIT
    rd_en = 1'b1; addr = 32'h20;
    tick(); rd_en = 1'b0; addr = '0; cnt = 0;
    for (int k = 0; k < 4; k++) begin tick(); if (rdata_valid) cnt++; end
    checks++; if (cnt !== 0) begin errors++; $display("FAIL abort_drop strobes=%0d exp=0", cnt); end
    // address changed in WAIT
    rd_en = 1'b1; addr = 32'h20;
    tick(); addr = 32'h24; cnt = 0;
    tick(); rd_en = 1'b0; addr = '0;
    if (rdata_valid) cnt++;
    for (int k = 0; k < 3; k++) begin tick(); if (rdata_valid) cnt++; end
    checks++; if (cnt !== 0) begin errors++; $display("FAIL abort_addr strobes=%0d exp=0", cnt); end
    // reset in WAIT
    rd_en = 1'b1; addr = 32'h20;
    tick(); rst = 1'b1; cnt = 0;
    tick(); rst = 1'b0; rd_en = 1'b0; addr = '0;
    if (rdata_valid) cnt++;
    for (int k = 0; k < 3; k++) begin tick(); if (rdata_valid) cnt++; end
    checks++; if (cnt !== 0) begin errors++; $display("FAIL reset_wait strobes=%0d exp=0", cnt); end
    // store during reset is dropped
    rst = 1'b1; wr_en = 1'b1; addr = 32'h24; wdata = ~ref_mem[9];
    tick(); rst = 1'b0; wr_en = 1'b0; addr = '0; wdata = '0;
    tick();
    load(32'h24, lat, d, e, s);
    checks++; if (d !== ref_mem[9]) begin errors++; $display("FAIL reset_write_drop got=%h exp=%h", d, ref_mem[9]); end
    load(32'h20, lat, d, e, s);
    checks++; if (lat !== LAT || s !== 1 || e !== 1'b0 || d !== ref_mem[8]) begin
      errors++; $display("FAIL post_reset_load got=lat%0d/s%0d/err%0b/%h exp=lat%0d/s1/err0/%h", lat, s, e, d, LAT, ref_mem[8]);
    end
  endtask

  task automatic test_collision();
    int cnt;
    rd_en = 1'b1; wr_en = 1'b1; addr = 32'h8; wdata = ~ref_mem[2];
    tick(); rd_en = 1'b0; wr_en = 1'b0; addr = '0; wdata = '0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL collide_err got=%0b exp=1", err); end
    cnt = 0;
    for (int k = 0; k < 3; k++) begin tick(); if (rdata_valid) cnt++; end
    checks++; if (cnt !== 0) begin errors++; $display("FAIL collide_strobe got=%0d exp=0", cnt); end
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 8) return 32'($urandom_range(0, 15) * 4);
    if (r == 8) return 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
    return 32'(4 * DEPTH + $urandom_range(0, 255) * 4);
  endfunction

  task automatic test_random();
    logic e; int lat; logic [31:0] d; int s; logic [31:0] a; logic [31:0] v;
    for (int n = 0; n < 40; n++) begin
      a = rand_addr();
      if ($urandom_range(0, 1) == 0) begin
        v = $urandom;
        store(a, v, e);
        checks++; if (e !== !addr_ok(a)) begin errors++; $display("FAIL rnd_store_err addr=%h got=%0b exp=%0b", a, e, !addr_ok(a)); end
      end else begin
        load(a, lat, d, e, s);
        checks++;
        if (lat !== LAT || s !== 1 || e !== !addr_ok(a) ||
            d !== (addr_ok(a) ? ref_mem[a >> 2] : 32'h0)) begin
          errors++;
          $display("FAIL rnd_load addr=%h got=lat%0d/s%0d/err%0b/%h exp=lat%0d/s1/err%0b/%h",
                   a, lat, s, e, d, LAT, !addr_ok(a), (addr_ok(a) ? ref_mem[a >> 2] : 32'h0));
        end
      end
    end
  endtask

`ifdef DMEM_PERF_EN
  task automatic test_perf();
    logic e; int lat; logic [31:0] d; int s;
    rst = 1'b1; tick(); rst = 1'b0; tick();
    checks++; if (rd_count !== 0 || wr_count !== 0) begin errors++; $display("FAIL perf_reset got=%0d/%0d exp=0/0", rd_count, wr_count); end
    load(32'h0, lat, d, e, s);
    load(32'h4, lat, d, e, s);
    store(32'h8, 32'hA5A5_0001, e);
    load(32'hC, lat, d, e, s);
    store(32'h3, 32'h0, e);
    store(32'h10, 32'hA5A5_0002, e);
    tick();
    checks++; if (rd_count !== 32'd3) begin errors++; $display("FAIL perf_rd got=%0d exp=3", rd_count); end
    checks++; if (wr_count !== 32'd2) begin errors++; $display("FAIL perf_wr got=%0d exp=2", wr_count); end
    force u_dut.wr_count_o = 32'hFFFF_FFFF;
    #1;
    release u_dut.wr_count_o;
    store(32'h14, 32'hA5A5_0003, e);
    tick();
    checks++; if (wr_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL perf_sat got=%h exp=ffffffff", wr_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_preload();
    test_basic();
    test_back_to_back();
    test_misaligned_store();
    test_out_of_range();
    test_abort_reset();
    test_collision();
    test_random();
`ifdef DMEM_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
